// File: rtl/mem_responder.sv
// mem_responder: turns single-cycle read/write request pulses from a control
// FSM into one-cycle SRAM access strobes and returns a one-cycle ready pulse
// per accepted request. Requests arriving while busy are dropped and recorded
// in a sticky overflow flag.
//
// Optional feature: define MEM_RESPONDER_IO_MAP_EN to compile in a
// memory-mapped I/O page (addr[15:8] == IO_BASE) that bypasses the SRAM.
//
// Handshake: memread/memwrite are accepted only when the FSM is IDLE. Each
// accepted request produces exactly one ready pulse. A request seen in any
// other state is dropped (no SRAM access, no ready) and sets ovf.
module mem_responder #(
  parameter int         RD_LAT  = 2,
  parameter logic [7:0] IO_BASE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        ovf,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_en,
  output logic        sram_we,
  input  logic [15:0] sram_rdata,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Counter reload: RD_WAIT lasts RD_LAT cycles, counting RD_LAT-1 down to 0.
  localparam logic [2:0] LP_WAIT = 3'(RD_LAT - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_rdata;
  logic        r_ovf;
  logic [15:0] r_sram_addr;
  logic [15:0] r_sram_wdata;
  logic        w_req;
  logic        w_io_hit;

  assign w_req = memread | memwrite;

`ifdef MEM_RESPONDER_IO_MAP_EN
  logic [15:0] r_io_out;
  assign w_io_hit = (addr[15:8] == IO_BASE);
  assign io_out   = r_io_out;
`else
  logic w_unused_io;
  assign w_io_hit    = 1'b0;
  assign io_out      = 16'h0000;
  assign w_unused_io = ^{io_in, IO_BASE};
`endif

  // Main FSM: request acceptance, SRAM sequencing, read capture, overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_rdata      <= 16'h0000;
      r_ovf        <= 1'b0;
      r_sram_addr  <= 16'h0000;
      r_sram_wdata <= 16'h0000;
`ifdef MEM_RESPONDER_IO_MAP_EN
      r_io_out     <= 16'h0000;
`endif
    end else begin
      if ((r_state != S_IDLE) && w_req) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // memwrite wins when both request lines are high.
          if (memwrite) begin
            if (w_io_hit) begin
`ifdef MEM_RESPONDER_IO_MAP_EN
              r_io_out <= wdata;
`endif
              r_state <= S_DONE;
            end else begin
              r_sram_addr  <= addr;
              r_sram_wdata <= wdata;
              r_state      <= S_WR_ISSUE;
            end
          end else if (memread) begin
            if (w_io_hit) begin
`ifdef MEM_RESPONDER_IO_MAP_EN
              r_rdata <= io_in;
`endif
              r_state <= S_DONE;
            end else begin
              r_sram_addr <= addr;
              r_state     <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          r_cnt   <= LP_WAIT;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rdata <= sram_rdata;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_WR_ISSUE: r_state <= S_DONE;
        S_DONE:     r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and ready decode straight from the state register, so each is
  // high for exactly the single cycle spent in the matching state.
  assign sram_en     = (r_state == S_RD_ISSUE) || (r_state == S_WR_ISSUE);
  assign sram_we     = (r_state == S_WR_ISSUE);
  assign ready       = (r_state == S_DONE);
  assign rdata       = r_rdata;
  assign ovf         = r_ovf;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed requests, an SRAM model with RD_LAT
// read latency, and a negedge monitor that pops expected read data (on ready)
// and expected SRAM accesses (on sram_en) from queues.
module tb_mem_responder;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        memread, memwrite;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        ready, ovf;
  logic [15:0] sram_addr, sram_wdata;
  logic        sram_en, sram_we;
  logic [15:0] sram_rdata, io_in, io_out;
  logic [2:0]  dbg_state;

  mem_responder #(.RD_LAT(RD_LAT), .IO_BASE(8'hFF)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .ovf(ovf),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_en(sram_en),
    .sram_we(sram_we), .sram_rdata(sram_rdata), .io_in(io_in),
    .io_out(io_out), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];   // rdata expected at each ready pulse
  logic [32:0] acc_q[$];   // {we, addr, wdata} expected at each sram_en
  logic [15:0] mem[256];
  logic [15:0] mon_e;
  logic [32:0] mon_a;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("ready_rdata", {24'h0, rdata}, {24'h0, mon_e});
      end
    end
    if (sram_en === 1'b1) begin
      if (acc_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_sram_en addr=%0h we=%0b", sram_addr, sram_we);
      end else begin
        mon_a = acc_q.pop_front();
        chk("sram_access", {7'h0, sram_we, sram_addr, sram_wdata}, {7'h0, mon_a});
      end
    end
    if (sram_we === 1'b1 && sram_en !== 1'b1) begin
      checks++; failures++;
      $display("FAIL we_without_en actual=1 required=0");
    end
  end

  // ---------------- SRAM model ----------------
  always @(negedge clk) begin
    if (sram_en === 1'b1 && sram_we === 1'b1) mem[sram_addr[7:0]] = sram_wdata;
  end

  // Read data valid for one cycle, RD_LAT cycles after the sram_en cycle.
  initial begin
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (sram_en === 1'b1 && sram_we === 1'b0) begin
        d = mem[sram_addr[7:0]];
        repeat (RD_LAT) @(posedge clk);
        #1 sram_rdata = d;
        @(posedge clk);
        #1 sram_rdata = 16'h0BAD;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives the request in cycle 0; returns 1ns into cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    memread = rd; memwrite = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  // Counts cycles (relative to the request cycle) until ready; also notes the
  // first cycle sram_en was seen in that window (-1 if never).
  task automatic wait_ready(input string name, input int start, input int exp_lat, input int exp_en);
    int k = start;
    int en_cyc = -1;
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sram_en === 1'b1 && en_cyc < 0) en_cyc = k;
      if (ready === 1'b1) begin seen = 1'b1; break; end
      k++;
    end
    if (!seen) k = -1;
    chk({name, "_latency"}, 40'(k), 40'(exp_lat));
    chk({name, "_en_cycle"}, 40'(en_cyc), 40'(exp_en));
  endtask

  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input int exp_lat);
    acc_q.push_back({wr, a, wr ? d : sram_wdata});
    exp_q.push_back(exp_rd);
    issue(rd, wr, a, d);
    wait_ready(name, 1, exp_lat, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rdy_cnt;
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
    addr = 16'h0; wdata = 16'h0; sram_rdata = 16'h0BAD; io_in = 16'h1234;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rdata", 40'(rdata), 40'h0);
    chk("rst_ready", 40'(ready), 40'h0);
    chk("rst_ovf", 40'(ovf), 40'h0);
    chk("rst_sram_en", 40'(sram_en), 40'h0);
    chk("rst_sram_we", 40'(sram_we), 40'h0);
    chk("rst_sram_addr", 40'(sram_addr), 40'h0);
    chk("rst_sram_wdata", 40'(sram_wdata), 40'h0);
    chk("rst_io_out", 40'(io_out), 40'h0);

    // Basic write then read-back; write leaves rdata alone.
    do_req("wr_0010", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2);
    do_req("rd_0010", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2 + RD_LAT);
    do_req("wr_0020", 1'b0, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 2);
    do_req("rd_0020", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 2 + RD_LAT);

    // Simultaneous read+write: write only.
    do_req("rdwr_0030", 1'b1, 1'b1, 16'h0030, 16'h5A5A, 16'h1234, 2);
    chk("rdwr_ovf", 40'(ovf), 40'h0);

    // Second read two cycles after the first: dropped, ovf sticks.
    acc_q.push_back({1'b0, 16'h0020, 16'h5A5A});
    exp_q.push_back(16'h1234);
    @(posedge clk); #1 memread = 1'b1; addr = 16'h0020;
    @(posedge clk); #1 memread = 1'b0;
    @(posedge clk); #1 memread = 1'b1; addr = 16'h0040;
    @(posedge clk); #1 memread = 1'b0;
    wait_ready("ovf_rd", 3, 2 + RD_LAT, -1);
    chk("ovf_set", 40'(ovf), 40'h1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", 40'(ovf), 40'h1);

    // Reset during RD_WAIT: no ready, rdata cleared, ovf cleared.
    acc_q.push_back({1'b0, 16'h0010, 16'h5A5A});
    @(posedge clk); #1 memread = 1'b1; addr = 16'h0010;
    @(posedge clk); #1 memread = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_rdata", 40'(rdata), 40'h0);
    chk("midrst_ovf", 40'(ovf), 40'h0);
    chk("midrst_sram_addr", 40'(sram_addr), 40'h0);
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready === 1'b1) rdy_cnt++;
      @(negedge clk);
    end
    chk("midrst_no_ready", 40'(rdy_cnt), 40'h0);
    do_req("wr_0050", 1'b0, 1'b1, 16'h0050, 16'hCAFE, 16'h0000, 2);
    do_req("rd_0050", 1'b1, 1'b0, 16'h0050, 16'h0000, 16'hCAFE, 2 + RD_LAT);
    chk("pre_done_ovf", 40'(ovf), 40'h0);

    // Request during the DONE cycle counts as busy.
    acc_q.push_back({1'b1, 16'h0060, 16'h1111});
    exp_q.push_back(16'hCAFE);
    @(posedge clk); #1 memwrite = 1'b1; addr = 16'h0060; wdata = 16'h1111;
    @(posedge clk); #1 memwrite = 1'b0;
    @(posedge clk); #1 memwrite = 1'b1; addr = 16'h0070; wdata = 16'h2222;
    @(negedge clk);
    chk("done_ready", 40'(ready), 40'h1);
    @(posedge clk); #1 memwrite = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_req_ovf", 40'(ovf), 40'h1);

`ifdef MEM_RESPONDER_IO_MAP_EN
    exp_q.push_back(16'hCAFE);
    issue(1'b0, 1'b1, 16'hFF02, 16'h00A5);
    wait_ready("io_wr", 1, 1, -1);
    chk("io_out_written", 40'(io_out), 40'h00A5);
    exp_q.push_back(16'h1234);
    issue(1'b1, 1'b0, 16'hFF02, 16'h0000);
    wait_ready("io_rd", 1, 1, -1);
`else
    do_req("io_wr_sram", 1'b0, 1'b1, 16'hFF02, 16'h00A5, 16'hCAFE, 2);
    chk("io_out_zero_wr", 40'(io_out), 40'h0);
    do_req("io_rd_sram", 1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h00A5, 2 + RD_LAT);
    chk("io_out_zero_rd", 40'(io_out), 40'h0);
`endif

    // Drain: every expected ready and access must have been consumed.
    repeat (4) @(negedge clk);
    chk("exp_q_empty", 40'(exp_q.size()), 40'h0);
    chk("acc_q_empty", 40'(acc_q.size()), 40'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
